// File: rtl/nios2_button_pio.sv
// Avalon-MM input PIO for pushbuttons/switches: two-flop synchroniser, per-bit
// debounce, edge capture with write-1-to-clear, and masked level interrupt.
module nios2_button_pio #(
  parameter int          WIDTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 1,
  parameter logic [31:0] IRQ_RESET_MASK  = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept, edge_hit, edge_clr;
  logic [WIDTH-1:0] edge_capture, irq_mask, read_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++)
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
  end

  // An accepted bit takes the value of sync2, so its direction is read from sync2.
  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0)      edge_hit = accept & sync2;
    else if (EDGE_TYPE == 1) edge_hit = accept & ~sync2;
    else                     edge_hit = accept;
  end

  always_comb begin
    edge_clr = '0;
    if (wr_en && address == 2'd3)
      edge_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux = stable;
      2'd1:    read_mux = '0;
      2'd2:    read_mux = irq_mask;
      default: read_mux = edge_capture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      sync1  <= in_port;
      sync2  <= sync1;
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i] || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  // A new edge wins over a simultaneous clear so it is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= IRQ_RESET_MASK[WIDTH-1:0];
      readdata     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_hit;
      if (wr_en && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      readdata <= 32'(read_mux);
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_button_pio.sv
// Bench for nios2_button_pio: falling-edge and any-edge instances driven in
// parallel, compared every cycle against a sample-window reference model.
module tb_nios2_button_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [W-1:0] in_port = '0;
  logic [31:0] readdata_f, readdata_a;
  logic        irq_f, irq_a;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios2_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IRQ_RESET_MASK(32'h0)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_f),
    .in_port(in_port), .irq(irq_f));

  nios2_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IRQ_RESET_MASK(32'h0)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port), .irq(irq_a));

  // Reference model: a bit is accepted once the last D synchronised samples
  // all disagree with the accepted value. hist[0] is the newest sample.
  logic [W-1:0] hist [0:D];
  logic [W-1:0] stable_m;
  logic [W-1:0] ec_m [2];
  logic [W-1:0] mask_m [2];
  logic [31:0]  rd_m [2];
  int           etype [2] = '{1, 2};

  function automatic logic [31:0] mux_m(int d, logic [1:0] a);
    case (a)
      2'd0:    return 32'(stable_m);
      2'd1:    return 32'h0;
      2'd2:    return 32'(mask_m[d]);
      default: return 32'(ec_m[d]);
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] acc, newst, clr, hit;
    bit all_diff;
    if (reset) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      stable_m = '0;
      for (int d = 0; d < 2; d++) begin
        ec_m[d] = '0; mask_m[d] = '0; rd_m[d] = 32'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) rd_m[d] = mux_m(d, address);
      acc = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++)
          if (hist[k][i] == stable_m[i]) all_diff = 1'b0;
        acc[i] = all_diff;
      end
      newst = stable_m ^ acc;
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int d = 0; d < 2; d++) begin
        if (etype[d] == 2)      hit = acc;
        else if (etype[d] == 1) hit = acc & ~newst;
        else                    hit = acc & newst;
        ec_m[d] = (ec_m[d] & ~clr) | hit;
        if (chipselect && !write_n && address == 2'd2) mask_m[d] = writedata[W-1:0];
      end
      stable_m = newst;
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
    end
  endtask

  task automatic check_outputs();
    logic exp_irq_f, exp_irq_a;
    exp_irq_f = |(ec_m[0] & mask_m[0]);
    exp_irq_a = |(ec_m[1] & mask_m[1]);
    vectors++;
    assert (readdata_f === rd_m[0]) else begin
      miscompares++;
      $error("FAIL readdata_fall got %h expected %h", readdata_f, rd_m[0]);
    end
    vectors++;
    assert (irq_f === exp_irq_f) else begin
      miscompares++;
      $error("FAIL irq_fall got %b expected %b", irq_f, exp_irq_f);
    end
    vectors++;
    assert (readdata_a === rd_m[1]) else begin
      miscompares++;
      $error("FAIL readdata_any got %h expected %h", readdata_a, rd_m[1]);
    end
    vectors++;
    assert (irq_a === exp_irq_a) else begin
      miscompares++;
      $error("FAIL irq_any got %b expected %b", irq_a, exp_irq_a);
    end
  endtask

  task automatic step(int n = 1);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(logic [1:0] a, int n = 1);
    address = a;
    step(n);
  endtask

  initial begin
    for (int k = 0; k <= D; k++) hist[k] = '0;
    stable_m = '0;
    for (int d = 0; d < 2; d++) begin
      ec_m[d] = '0; mask_m[d] = '0; rd_m[d] = 32'h0;
    end

    // Reset defaults
    step(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    bus_read(2'd0);

    // Debounce accept of a falling bit
    bus_write(2'd2, 32'hF);
    in_port = 4'hF;
    bus_read(2'd0, 10);
    bus_write(2'd3, 32'hF);
    in_port = 4'hE;
    bus_read(2'd0, 6);
    bus_read(2'd3, 2);
    vectors++;
    assert (readdata_f === 32'h1 && irq_f === 1'b1) else begin
      miscompares++;
      $error("FAIL accept_capture got rd=%h irq=%b expected rd=1 irq=1", readdata_f, irq_f);
    end

    // Glitch shorter than the debounce window
    bus_write(2'd3, 32'hF);
    bus_write(2'd3, 32'hF);
    in_port = 4'hC;
    bus_read(2'd0, 3);
    in_port = 4'hE;
    bus_read(2'd0, 4);
    bus_read(2'd3, 4);
    vectors++;
    assert (readdata_f === 32'h0 && irq_f === 1'b0) else begin
      miscompares++;
      $error("FAIL glitch_reject got rd=%h irq=%b expected rd=0 irq=0", readdata_f, irq_f);
    end

    // Mask and clear
    in_port = 4'hF;
    bus_read(2'd0, 8);
    in_port = 4'hE;
    bus_read(2'd0, 8);
    bus_write(2'd2, 32'h0);
    bus_read(2'd3, 2);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 2);
    bus_write(2'd2, 32'hF);

    // Set/clear collision on bit 2
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, 1);
    in_port = 4'hA;
    step(5);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, 1);
    vectors++;
    assert (readdata_f[2] === 1'b1 && irq_f === 1'b1) else begin
      miscompares++;
      $error("FAIL collision got rd=%h irq=%b expected bit2=1 irq=1", readdata_f, irq_f);
    end

    // Any-edge capture on bit 3
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h8);
    in_port = 4'h2;
    bus_read(2'd1, 8);
    bus_write(2'd3, 32'hF);
    in_port = 4'hA;
    bus_read(2'd1, 8);
    vectors++;
    assert (irq_a === 1'b1 && readdata_a === 32'h0) else begin
      miscompares++;
      $error("FAIL any_edge_rise got irq=%b rd=%h expected irq=1 rd=0", irq_a, readdata_a);
    end

    // Randomised traffic, including resets mid-debounce
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(5) == 0) in_port = W'($urandom);
      address = 2'($urandom);
      writedata = (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | 32'($urandom_range(15));
      if ($urandom_range(7) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = $urandom_range(1) == 1; write_n = 1'b1;
      end
      step();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios2_button_pio.md
# nios2_button_pio

Avalon-MM slave input port for pushbuttons and switches: the read-side counterpart of the Nios II output PIOs that drive the hex displays. Each input bit is synchronised, debounced and edge-detected. Detected edges latch into an edge-capture register, and masked captures raise a level-sensitive interrupt to the Nios II. Register map matches the standard PIO layout, so the existing HAL PIO driver and ISRs work unchanged.

## Interface
- WIDTH, 4: number of input bits (1-32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles (≥1) before a change is accepted; 1 = no filtering.
- EDGE_TYPE, 1: 0 = rising, 1 = falling (active-low buttons), 2 = any edge.
- IRQ_RESET_MASK, 0: interruptmask value after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select, word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH-1 are ignored.
- readdata  out  32  registered read data, zero-extended above WIDTH-1.
- in_port  in  WIDTH  asynchronous board inputs.
- irq  out  1  level interrupt request.

## Operation
- Register map:
  - 0 = data: read-only, returns the debounced value; writes are ignored.
  - 1 = direction: reads 0; writes are ignored.
  - 2 = interruptmask: read/write.
  - 3 = edgecapture: read; write-1-to-clear per bit.
- Synchroniser: two flops per bit (sync1, sync2).
- Debounce, per bit, using counter cnt (width clog2(DEBOUNCE_CYCLES)) and register stable:
  - If sync2 == stable: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable ← sync2 and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any mismatch gap restarts the count; a glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Edge detect: fires on the same clock edge that stable updates, if the direction matches EDGE_TYPE. It sets edgecapture[i].
- Edgecapture clear: a write with address == 3 and writedata[i] == 1 clears bit i.
  - If a set and a clear hit the same bit on the same cycle, set wins; the edge is not lost.
- Interruptmask: written on chipselect & ~write_n & address == 2.
- irq = |(edgecapture & interruptmask), decoded combinationally from registers. Changing the mask affects irq the cycle after the write.
- Reads: readdata ← {zero-extend(mux[address])} on every clock. There is no read strobe and reads have no side effects.
- Reset values: sync1/sync2/stable/cnt = 0, edgecapture = 0, interruptmask = IRQ_RESET_MASK, readdata = 0, irq = 0 (unless IRQ_RESET_MASK ≠ 0 and a capture already exists, which is impossible since captures reset to 0).
- Reset mid-debounce discards the partial count; no edge is reported for a transition interrupted by reset.
- Inputs held at 1 across reset produce one rising acceptance after DEBOUNCE_CYCLES. Software must clear edgecapture after init.

## Timing
- in_port first sampled at edge N:
  - sync2 holds the new value after N+1.
  - stable and edgecapture update at edge N+1+DEBOUNCE_CYCLES.
  - irq is high after that edge.
- Read latency: 1 clock. Address presented at edge K, readdata valid after edge K+1; the Avalon readLatency = 1.
- Write takes effect at the edge it is presented; a read of the same register issued on the next cycle returns the new value.
- Edgecapture clear to irq deassert: 0 cycles after the write edge, unless a simultaneous edge re-sets the bit.
- Throughput: one access per clock, no waitrequest.

## Test plan
1. Reset defaults: assert reset 2 cycles with WIDTH=4, IRQ_RESET_MASK=0 -> readdata reads 0 at all four addresses, irq = 0.
2. Debounce accept (DEBOUNCE_CYCLES=4, EDGE_TYPE=1): set mask = 0xF, drive in_port 0xF for 10 cycles, then drop bit 0 to 0 at edge N.
   - data reads 0xE from edge N+5.
   - edgecapture reads 0x1 and irq = 1 after edge N+5.
3. Glitch reject (DEBOUNCE_CYCLES=4): pulse bit 1 low for 3 cycles -> data stays 0xF, edgecapture = 0, irq = 0.
4. Clear and mask:
   - With edgecapture = 0x1, write 0x0 to mask -> irq = 0 and edgecapture still reads 0x1.
   - Write 0x1 to address 3 -> edgecapture = 0 on the next read.
5. Set/clear collision: write 0x4 to edgecapture on the same cycle bit 2 stable falls -> edgecapture bit 2 reads 1, irq = 1.
6. EDGE_TYPE=2 with mask = 0x8: toggle bit 3 down, clear, then up -> one capture per transition, irq asserted twice. Address 1 reads 0 throughout.
